// File: rtl/stm_storage.sv
// Microprocessor-accessible register file: ID/version constants, a write counter and 61
// general byte registers with a registered, read-before-write data output.
module stm_storage (
    input  logic       Clock,
    input  logic       Rst_n,
    input  logic       Mpi_enb,
    input  logic       Rw,
    input  logic [5:0] Addr_in,
    input  logic [7:0] Data_in,
    output logic [7:0] Data_out
);

    localparam logic [7:0] IdValue      = 8'hA5;
    localparam logic [7:0] VersionValue = 8'h01;
    localparam int unsigned FirstGen    = 3;
    localparam int unsigned LastGen     = 63;

    logic [7:0] regs_q [FirstGen:LastGen];
    logic [7:0] regs_d [FirstGen:LastGen];
    logic [7:0] wcnt_q, wcnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       wr_stb;

    assign wr_stb = Mpi_enb && !Rw;

    always_comb begin
        regs_d = regs_q;
        wcnt_d = wcnt_q;
        if (wr_stb) begin
            // Every write strobe counts, including ones aimed at the read-only locations.
            wcnt_d = wcnt_q + 8'd1;
            for (int i = FirstGen; i <= LastGen; i++) begin
                if (Addr_in == 6'(i)) begin
                    regs_d[i] = Data_in;
                end
            end
        end
    end

    // Read mux looks at current state, so a coincident write is seen one edge later.
    always_comb begin
        data_out_d = 8'h00;
        unique case (Addr_in)
            6'd0:    data_out_d = IdValue;
            6'd1:    data_out_d = VersionValue;
            6'd2:    data_out_d = wcnt_q;
            default: begin
                for (int i = FirstGen; i <= LastGen; i++) begin
                    if (Addr_in == 6'(i)) begin
                        data_out_d = regs_q[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = FirstGen; i <= LastGen; i++) begin
                regs_q[i] <= 8'h00;
            end
            wcnt_q     <= 8'h00;
            data_out_q <= 8'h00;
        end else begin
            regs_q     <= regs_d;
            wcnt_q     <= wcnt_d;
            data_out_q <= data_out_d;
        end
    end

    assign Data_out = data_out_q;

endmodule

// File: tb/tb_stm_storage.sv
// Directed and random bench for stm_storage, checked against a byte-array model of the map.
module tb_stm_storage;

    logic       Clock;
    logic       Rst_n;
    logic       Mpi_enb;
    logic       Rw;
    logic [5:0] Addr_in;
    logic [7:0] Data_in;
    logic [7:0] Data_out;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: plain memory image plus a write count.
    logic [7:0] mem [64];
    int unsigned wcnt;

    stm_storage dut (
        .Clock    (Clock),
        .Rst_n    (Rst_n),
        .Mpi_enb  (Mpi_enb),
        .Rw       (Rw),
        .Addr_in  (Addr_in),
        .Data_in  (Data_in),
        .Data_out (Data_out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [7:0] model_read(input logic [5:0] a);
        if (a == 6'd0) return 8'hA5;
        if (a == 6'd1) return 8'h01;
        if (a == 6'd2) return 8'(wcnt % 256);
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        wcnt = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive, take the edge, update the model, check the registered read.
    task automatic cycle(input logic enb, input logic rw, input logic [5:0] a,
                         input logic [7:0] d, input string tag);
        logic [7:0] exp;
        Mpi_enb = enb;
        Rw      = rw;
        Addr_in = a;
        Data_in = d;
        @(posedge Clock);
        exp = model_read(a);
        if (enb && !rw) begin
            wcnt = (wcnt + 1) % 256;
            if (a >= 6'd3) mem[a] = d;
        end
        #1;
        chk(tag, Data_out, exp);
    endtask

    initial begin
        Rst_n   = 1'b0;
        Mpi_enb = 1'b0;
        Rw      = 1'b1;
        Addr_in = 6'd0;
        Data_in = 8'h00;
        model_reset();
        #2;
        chk("reset_dout", Data_out, 8'h00);
        @(negedge Clock);
        Rst_n = 1'b1;

        // Constants and counter straight out of reset
        cycle(1'b0, 1'b1, 6'h00, 8'h00, "id");
        chk("id_const", Data_out, 8'hA5);
        cycle(1'b0, 1'b1, 6'h01, 8'h00, "version");
        chk("version_const", Data_out, 8'h01);
        cycle(1'b0, 1'b1, 6'h02, 8'h00, "wcnt_reset");
        chk("wcnt_reset_const", Data_out, 8'h00);

        // Single write then readback
        cycle(1'b1, 1'b0, 6'h10, 8'h3C, "wr_10");
        cycle(1'b0, 1'b1, 6'h10, 8'h00, "rd_10");
        chk("rd_10_const", Data_out, 8'h3C);
        cycle(1'b0, 1'b1, 6'h02, 8'h00, "wcnt_1");
        chk("wcnt_1_const", Data_out, 8'h01);

        // Writes to read-only locations are dropped but counted
        cycle(1'b1, 1'b0, 6'h00, 8'hFF, "wr_ro0");
        cycle(1'b1, 1'b0, 6'h01, 8'hFF, "wr_ro1");
        cycle(1'b1, 1'b0, 6'h02, 8'hFF, "wr_ro2");
        cycle(1'b0, 1'b1, 6'h00, 8'h00, "ro0_kept");
        chk("ro0_kept_const", Data_out, 8'hA5);
        cycle(1'b0, 1'b1, 6'h01, 8'h00, "ro1_kept");
        chk("ro1_kept_const", Data_out, 8'h01);
        cycle(1'b0, 1'b1, 6'h02, 8'h00, "wcnt_4");
        chk("wcnt_4_const", Data_out, 8'h04);

        // Read-before-write on the same location, read strobe is side-effect free
        cycle(1'b1, 1'b0, 6'h20, 8'h11, "wr20_11");
        cycle(1'b1, 1'b0, 6'h20, 8'h22, "rbw_old");
        chk("rbw_old_const", Data_out, 8'h11);
        cycle(1'b1, 1'b1, 6'h20, 8'h99, "rbw_new");
        chk("rbw_new_const", Data_out, 8'h22);
        cycle(1'b0, 1'b0, 6'h20, 8'h77, "idle_20");
        chk("idle_20_const", Data_out, 8'h22);

        // Counter sampled before its own increment
        cycle(1'b1, 1'b0, 6'h02, 8'h00, "wcnt_pre");
        chk("wcnt_pre_const", Data_out, 8'h06);

        // 256 back-to-back writes wrap the counter to where it started
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 1'b0, 6'($urandom_range(63, 3)), 8'($urandom), "burst");
        end
        cycle(1'b0, 1'b1, 6'h02, 8'h00, "wcnt_wrap");
        chk("wcnt_wrap_const", Data_out, 8'h07);

        // Random mix of reads, writes and idle cycles
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom), 1'($urandom), 6'($urandom), 8'($urandom), "random");
        end

        // Asynchronous reset between edges clears output and storage
        cycle(1'b1, 1'b0, 6'h3F, 8'h5A, "wr_3f");
        cycle(1'b0, 1'b1, 6'h3F, 8'h00, "rd_3f");
        chk("rd_3f_const", Data_out, 8'h5A);
        @(negedge Clock);
        Rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_dout", Data_out, 8'h00);

        // Write strobe held across an edge while in reset must be discarded
        Mpi_enb = 1'b1;
        Rw      = 1'b0;
        Addr_in = 6'h05;
        Data_in = 8'h77;
        @(posedge Clock);
        #1;
        chk("rst_blocks_dout", Data_out, 8'h00);
        @(negedge Clock);
        Rst_n   = 1'b1;
        Mpi_enb = 1'b0;
        cycle(1'b0, 1'b1, 6'h3F, 8'h00, "3f_cleared");
        chk("3f_cleared_const", Data_out, 8'h00);
        cycle(1'b0, 1'b1, 6'h05, 8'h00, "rst_write_dropped");
        cycle(1'b0, 1'b1, 6'h02, 8'h00, "wcnt_after_rst");
        chk("wcnt_after_rst_const", Data_out, 8'h00);

        // First edge after release honours a strobe
        cycle(1'b1, 1'b0, 6'h08, 8'hC3, "wr_first");
        cycle(1'b0, 1'b1, 6'h08, 8'h00, "rd_first");
        chk("rd_first_const", Data_out, 8'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stm_storage.md
STM_STORAGE -- requirements
Module: stm_storage

Interface
REQ-001 The block SHALL have no parameters; the address width is fixed at 6 bits and the data width at 8 bits.
REQ-002 Clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Mpi_enb  input  1  access strobe, synchronous to Clock; one-cycle pulse per uP access.
REQ-005 Rw  input  1  access direction, sampled only when Mpi_enb=1; 1 = read, 0 = write.
REQ-006 Addr_in  input  6  register address, 0x00..0x3F.
REQ-007 Data_in  input  8  write data, sampled only when Mpi_enb=1 and Rw=0.
REQ-008 Data_out  output  8  registered read data.

Function
REQ-009 The address map SHALL be:
- 0x00: read-only ID, constant 8'hA5.
- 0x01: read-only version, constant 8'h01.
- 0x02: read-only write counter WCNT.
- 0x03..0x3F: 61 general read/write byte registers.
REQ-010 A write SHALL occur on the rising edge where Mpi_enb=1 and Rw=0. When Addr_in is 0x03..0x3F, the register at Addr_in SHALL load Data_in.
REQ-011 Writes to 0x00..0x02 SHALL leave all register contents unchanged.
REQ-012 WCNT SHALL increment by 1 on every write strobe (Mpi_enb=1, Rw=0), whatever the address, including 0x00..0x02.
REQ-013 WCNT SHALL be 8 bits and wrap from 8'hFF to 8'h00.
REQ-014 A read strobe (Mpi_enb=1, Rw=1) SHALL have no side effects.
REQ-015 With Mpi_enb=0, no register and no WCNT SHALL change.
REQ-016 Data_out SHALL update on every rising edge, regardless of Mpi_enb and Rw, to the content of the location at Addr_in; latency is one cycle from Addr_in.
REQ-017 Read-before-write: on the edge where a write hits the location at Addr_in, Data_out SHALL capture the old value; the new value SHALL appear on the following edge if Addr_in is unchanged.
REQ-018 For Addr_in = 0x02 on the same edge as a write strobe, Data_out SHALL capture WCNT before the increment.
REQ-019 Mpi_enb held high for several consecutive cycles SHALL be treated as one access per cycle; each cycle's write increments WCNT.
REQ-020 Only values 0 and 1 on Rw are defined; X/Z handling is unspecified.

Reset
REQ-021 While Rst_n=0, the block SHALL asynchronously force:
- all general registers 0x03..0x3F to 8'h00;
- WCNT to 8'h00;
- Data_out to 8'h00.
REQ-022 Reset asserted mid-operation SHALL discard any pending write on that edge; Rst_n low has priority over Mpi_enb.
REQ-023 After Rst_n deasserts, the first rising edge SHALL resume normal operation: a strobe on that edge is honoured, and Data_out reflects Addr_in.
REQ-024 ID and version SHALL read their constants at all times outside reset, with no dependence on reset.

Verification
REQ-025 After reset, Addr_in=0x00/0x01/0x02 on successive cycles -> Data_out = 8'hA5, 8'h01, 8'h00, each one cycle later.
REQ-026 Write 8'h3C to 0x10 (one-cycle Mpi_enb, Rw=0), then Addr_in=0x10 -> Data_out = 8'h3C; Addr_in=0x02 -> Data_out = 8'h01.
REQ-027 Write 8'hFF to 0x00 and to 0x01 -> reads still return 8'hA5 and 8'h01; WCNT increases by 2.
REQ-028 With Addr_in=0x20 holding 8'h11, write 8'h22 to 0x20 -> Data_out = 8'h11 on the write edge and 8'h22 on the next edge; a read strobe to 0x20 changes nothing.
REQ-029 Perform 256 writes -> WCNT reads 8'h00 (wrap).
REQ-030 Write 8'h5A to 0x3F, pulse Rst_n low between clock edges -> Data_out and 0x3F become 8'h00 immediately, with no clock edge required.
